// File: rtl/ahb_pkg.sv
// Shared AHB-Lite constants and the fetch-master state/error encodings.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic       HRESP_OKAY    = 1'b0;
  localparam logic       HRESP_ERROR   = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ADDR = 2'b01,
    ST_DATA = 2'b10,
    ST_DONE = 2'b11
  } fetch_state_t;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_MISALIGN = 2'b01,
    ERR_BUSERR   = 2'b10,
    ERR_TIMEOUT  = 2'b11
  } fetch_err_t;

endpackage

// File: rtl/ahb_fetch_master_if.sv
// AHB-Lite single-master bus bundle used by the instruction fetch path.
interface ahb_fetch_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] HADDR;
  logic [1:0]        HTRANS;
  logic [2:0]        HSIZE;
  logic [2:0]        HBURST;
  logic              HWRITE;
  logic [3:0]        HPROT;
  logic [DATA_W-1:0] HRDATA;
  logic              HREADY;
  logic              HRESP;

  modport master (
    output HADDR, HTRANS, HSIZE, HBURST, HWRITE, HPROT,
    input  HRDATA, HREADY, HRESP
  );

  modport slave (
    input  HADDR, HTRANS, HSIZE, HBURST, HWRITE, HPROT,
    output HRDATA, HREADY, HRESP
  );
endinterface

// File: rtl/ahb_fetch_master.sv
// Single-beat AHB-Lite instruction fetch master with misalign, bus-error and
// stalled-slave timeout reporting.
//   state | meaning
//   IDLE  | waiting for fetch_req
//   ADDR  | address phase, NONSEQ driven
//   DATA  | data phase, waiting for HREADY
//   DONE  | one-cycle instr_valid / fetch_err report
module ahb_fetch_master
  import ahb_pkg::*;
#(
  parameter int         ADDR_W      = 32,
  parameter int         DATA_W      = 32,
  parameter logic [3:0] HPROT_VAL   = 4'b0010,
  parameter int         TIMEOUT_CYC = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 fetch_req,
  input  logic [ADDR_W-1:0]    pc_addr,
  output logic [DATA_W-1:0]    instr,
  output logic                 instr_valid,
  output logic                 fetch_err,
  output logic [1:0]           err_code,
  output logic                 fetch_busy,
  ahb_fetch_master_if.master   bus
);

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYC - 1);

  fetch_state_t      state_q, state_d;
  fetch_err_t        err_code_q, err_code_d;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        wait_cnt_q, wait_cnt_d;
  logic              valid_d, err_d, load_instr;

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    err_code_d = err_code_q;
    valid_d    = 1'b0;
    err_d      = 1'b0;
    load_instr = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (fetch_req) begin
          if (pc_addr[1:0] != 2'b00) begin
            state_d    = ST_DONE;
            err_d      = 1'b1;
            err_code_d = ERR_MISALIGN;
          end else begin
            state_d    = ST_ADDR;
            wait_cnt_d = '0;
          end
        end
      end
      ST_ADDR: begin
        if (bus.HREADY) begin
          state_d    = ST_DATA;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d    = ST_DONE;
          err_d      = 1'b1;
          err_code_d = ERR_TIMEOUT;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      ST_DATA: begin
        // first cycle of an ERROR response has HREADY low; only the second one ends the transfer
        if (bus.HREADY) begin
          state_d = ST_DONE;
          if (bus.HRESP == HRESP_ERROR) begin
            err_d      = 1'b1;
            err_code_d = ERR_BUSERR;
          end else begin
            valid_d    = 1'b1;
            load_instr = 1'b1;
          end
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d    = ST_DONE;
          err_d      = 1'b1;
          err_code_d = ERR_TIMEOUT;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      err_code_q  <= ERR_NONE;
      addr_q      <= '0;
      wait_cnt_q  <= '0;
      instr       <= '0;
      instr_valid <= 1'b0;
      fetch_err   <= 1'b0;
    end else begin
      state_q     <= state_d;
      err_code_q  <= err_code_d;
      wait_cnt_q  <= wait_cnt_d;
      instr_valid <= valid_d;
      fetch_err   <= err_d;
      if (state_q == ST_IDLE && fetch_req) addr_q <= pc_addr;
      if (load_instr) instr <= bus.HRDATA;
    end
  end

  assign err_code   = err_code_q;
  assign fetch_busy = (state_q != ST_IDLE);

  assign bus.HTRANS = (state_q == ST_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign bus.HADDR  = addr_q;
  assign bus.HSIZE  = HSIZE_WORD;
  assign bus.HBURST = HBURST_SINGLE;
  assign bus.HWRITE = 1'b0;
  assign bus.HPROT  = HPROT_VAL;

endmodule

// File: doc/ahb_fetch_master.md
# ahb_fetch_master

Instruction-fetch bus master for the multicycle core. Takes the PC address when the control FSM requests a fetch, runs one single-beat AHB-Lite word read, and returns the instruction word with a one-cycle valid pulse. It also reports bus errors, misaligned addresses and stalled-slave timeouts. It sits between `program_counter` (address source) and the instruction register / control FSM.

## Interface
- `ADDR_W`, 32, address width.
- `DATA_W`, 32, data and instruction width.
- `HPROT_VAL`, 4'b0010, HPROT driven on every fetch: opcode fetch, privileged, non-bufferable, non-cacheable.
- `TIMEOUT_CYC`, 255, maximum consecutive HREADY-low cycles tolerated per transfer.
- `clk` in 1: clock. All logic is rising-edge.
- `reset` in 1: reset, asynchronous, active-high.
- `fetch_req` in 1: start a fetch. Sampled only in IDLE.
- `pc_addr` in ADDR_W: fetch address. Captured on an accepted `fetch_req`.
- `instr` out DATA_W: last successfully fetched word. Holds until the next success.
- `instr_valid` out 1: one-cycle pulse when `instr` is updated.
- `fetch_err` out 1: one-cycle pulse on an error-terminated fetch.
- `err_code` out 2: cause of the last error. 01 = misaligned, 10 = HRESP ERROR, 11 = timeout. Held until the next error.
- `fetch_busy` out 1: high in every state except IDLE.
- `HADDR` out ADDR_W: AHB address.
- `HTRANS` out 2: AHB transfer type.
- `HSIZE` out 3: constant 3'b010 (word).
- `HBURST` out 3: constant 3'b000 (SINGLE).
- `HWRITE` out 1: constant 0.
- `HPROT` out 4: constant `HPROT_VAL`.
- `HRDATA` in DATA_W: AHB read data.
- `HREADY` in 1: AHB ready.
- `HRESP` in 1: AHB response. 0 = OKAY, 1 = ERROR.

## Operation
- States:
  - IDLE
  - ADDR: address phase
  - DATA: data phase
  - DONE: report cycle
- IDLE:
  - `fetch_req`=1 captures `pc_addr` into `addr_q`.
  - If `pc_addr[1:0]` != 0: go to DONE with a misaligned error. No bus transfer is issued.
  - Otherwise go to ADDR.
- ADDR:
  - Drive HTRANS=NONSEQ (2'b10) and HADDR=`addr_q`.
  - Hold both while HREADY=0.
  - On HREADY=1, go to DATA.
- DATA:
  - Drive HTRANS=IDLE (2'b00). HADDR keeps `addr_q`.
  - On HREADY=1 with HRESP=0: capture HRDATA into `instr` and go to DONE (success).
  - On HRESP=1 (either cycle of the two-cycle error response): go to DONE with error code 10 once HREADY=1.
- DONE:
  - Pulse `instr_valid` or `fetch_err` for exactly one cycle.
  - Return to IDLE.
- Timeout:
  - An 8-bit wait counter clears on entry to ADDR and on the ADDR→DATA transition.
  - It increments on each HREADY=0 cycle in ADDR or DATA.
  - When it reaches `TIMEOUT_CYC`, go to DONE with code 11.
  - If the timeout fires in ADDR, HTRANS drops to IDLE. This is a permitted protocol abandonment for a hung slave.
- Outside ADDR, HTRANS is always IDLE. At most one transfer is outstanding.
- `fetch_req` in any state other than IDLE is ignored. It is not queued.
- `instr` is never modified on error or misalignment.

## Timing
- Reset values:
  - State = IDLE.
  - HTRANS=2'b00, HADDR=0.
  - `instr`=0.
  - `instr_valid`=0, `fetch_err`=0, `err_code`=0.
  - `fetch_busy`=0.
  - Wait counter = 0.
- Outputs are registered, except that HTRANS, HADDR and `fetch_busy` decode directly from state/`addr_q` registers.
- Zero-wait-state latency:
  - `fetch_req` sampled at edge 0.
  - ADDR during cycle 1.
  - DATA during cycle 2.
  - `instr_valid` high during cycle 3.
  - Total: 3 cycles request-to-valid.
- Each HREADY-low cycle in ADDR or DATA adds one cycle.
- Misaligned request: `fetch_err` is high during cycle 1.
- Earliest next accepted `fetch_req` is the cycle after DONE, giving 4-cycle fetch throughput.
- Asserting `reset` mid-transfer forces HTRANS=IDLE immediately (asynchronously) and discards the in-flight fetch. No pulse is generated.

## Structure
- Shared package `ahb_pkg` holds:
  - `HTRANS_IDLE`, `HTRANS_NONSEQ`.
  - `HSIZE_WORD`, `HBURST_SINGLE`.
  - `HRESP_OKAY`, `HRESP_ERROR`.
  - enum `fetch_state_t` (IDLE, ADDR, DATA, DONE).
  - enum `fetch_err_t` (NONE, MISALIGN, BUSERR, TIMEOUT).
- Single module, no sub-modules. The timeout counter is inline.

## Test plan
- Zero-wait fetch:
  - Stimulus: `pc_addr`=A0000000, slave returns 00500093.
  - Required: HTRANS=NONSEQ for exactly 1 cycle, `instr`=00500093, `instr_valid` 3 cycles after req.
- Wait states:
  - Stimulus: HREADY low 2 cycles in ADDR and 3 cycles in DATA, addr A000001C.
  - Required: HADDR and HTRANS stable while stalled, `instr_valid` at cycle 8, `fetch_busy` high throughout.
- Bus error:
  - Stimulus: HRESP=1 with HREADY=0, then HRESP=1 with HREADY=1.
  - Required: `fetch_err` pulse, `err_code`=10, `instr` unchanged, HTRANS=IDLE in both cycles.
- Misaligned:
  - Stimulus: `pc_addr`=A0000002.
  - Required: no NONSEQ ever driven, `fetch_err` next cycle, `err_code`=01.
- Timeout and ignored request:
  - Stimulus: HREADY held low 255 cycles, with `fetch_req` asserted while busy.
  - Required: `err_code`=11, return to IDLE, the busy request is not serviced.
- Reset mid-DATA:
  - Stimulus: assert `reset` during DATA.
  - Required: all outputs at reset values immediately, no `instr_valid`, clean fetch afterwards.
